// File: rtl/compare_pkg.sv
// Shared result codes and FSM state encodings for the compare stage.
package compare_pkg;

  typedef enum logic [1:0] {
    CMP_NONE    = 2'b00,
    CMP_LESS    = 2'b01,
    CMP_EQUAL   = 2'b10,
    CMP_GREATER = 2'b11
  } cmp_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_CAPTURE = 2'b01,
    S_EVAL    = 2'b10,
    S_OUT     = 2'b11
  } state_e;

endpackage

// File: rtl/compare_diff_abs.sv
// Combinational signed compare: three-way code plus unsigned |a - b| in WIDTH bits.
module compare_diff_abs
  import compare_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic        [1:0]       code,
  output logic        [WIDTH-1:0] mag
);

  // |diff| never exceeds 2^WIDTH-1, so dropping the sign bit loses nothing.
  function automatic logic [WIDTH-1:0] abs_trunc(input logic signed [WIDTH:0] v);
    return WIDTH'(v[WIDTH] ? -v : v);
  endfunction

  logic signed [WIDTH:0] diff;

  always_comb begin
    diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    mag  = abs_trunc(diff);
    if (diff[WIDTH])
      code = CMP_LESS;
    else if (diff == '0)
      code = CMP_EQUAL;
    else
      code = CMP_GREATER;
  end

endmodule

// File: rtl/compare_gen.sv
// Handshaked signed compare stage: start edge, capture, evaluate, hold result HOLD cycles.
module compare_gen
  import compare_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HOLD  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_rdy,
  input  logic signed [WIDTH-1:0] data_in,
  input  logic signed [WIDTH-1:0] ref_in,
  output logic                    out_rdy,
  output logic        [1:0]       cmp_state,
  output logic        [WIDTH-1:0] data_out,
  output logic                    busy,
  output logic                    ovr_err
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  state_e                  state_q, state_d;
  logic                    in_rdy_q;
  logic signed [WIDTH-1:0] d_q, d_d, r_q, r_d;
  logic        [1:0]       cmp_q, cmp_d;
  logic        [WIDTH-1:0] mag_q, mag_d;
  logic                    out_rdy_q, out_rdy_d;
  logic        [HW-1:0]    hold_q, hold_d;
  logic                    ovr_q, ovr_d;
  logic                    start;
  logic        [1:0]       code_w;
  logic        [WIDTH-1:0] mag_w;

  compare_diff_abs #(.WIDTH(WIDTH)) u_diff (
    .a    (d_q),
    .b    (r_q),
    .code (code_w),
    .mag  (mag_w)
  );

  always_comb begin
    start     = in_rdy & ~in_rdy_q;
    state_d   = state_q;
    d_d       = d_q;
    r_d       = r_q;
    cmp_d     = cmp_q;
    mag_d     = mag_q;
    out_rdy_d = out_rdy_q;
    hold_d    = hold_q;
    ovr_d     = ovr_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        d_d     = data_in;
        r_d     = ref_in;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        cmp_d     = code_w;
        mag_d     = mag_w;
        out_rdy_d = 1'b1;
        hold_d    = HW'(HOLD - 1);
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (hold_q == '0) begin
          cmp_d     = CMP_NONE;
          mag_d     = '0;
          out_rdy_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Only IDLE accepts a start; anything else is a dropped request.
    if (start && state_q != S_IDLE) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      in_rdy_q  <= 1'b0;
      d_q       <= '0;
      r_q       <= '0;
      cmp_q     <= '0;
      mag_q     <= '0;
      out_rdy_q <= 1'b0;
      hold_q    <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_rdy_q  <= in_rdy;
      d_q       <= d_d;
      r_q       <= r_d;
      cmp_q     <= cmp_d;
      mag_q     <= mag_d;
      out_rdy_q <= out_rdy_d;
      hold_q    <= hold_d;
      ovr_q     <= ovr_d;
    end
  end

  assign out_rdy   = out_rdy_q;
  assign cmp_state = cmp_q;
  assign data_out  = mag_q;
  assign busy      = (state_q != S_IDLE);
  assign ovr_err   = ovr_q;

endmodule

// File: tb/tb_compare_gen.sv
// Randomised plus directed bench for compare_gen with an edge-indexed transaction model.
module tb_compare_gen;

  localparam int WIDTH = 8;
  localparam int HOLD  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_rdy = 1'b0;
  logic signed [7:0] data_in = '0;
  logic signed [7:0] ref_in = '0;
  logic              out_rdy;
  logic [1:0]        cmp_state;
  logic [7:0]        data_out;
  logic              busy;
  logic              ovr_err;

  int pass_n = 0;
  int total_n = 0;
  bit cyc_en = 1'b0;

  compare_gen #(.WIDTH(WIDTH), .HOLD(HOLD)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .in_rdy    (in_rdy),
    .data_in   (data_in),
    .ref_in    (ref_in),
    .out_rdy   (out_rdy),
    .cmp_state (cmp_state),
    .data_out  (data_out),
    .busy      (busy),
    .ovr_err   (ovr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: edges counted since reset; an accepted start at edge k owns edges k..k+2+HOLD.
  int                m_edge, m_k, m_free;
  bit                m_prev, m_ovr;
  logic signed [7:0] m_d, m_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edge <= 0;
      m_prev <= 1'b0;
      m_k    <= -100;
      m_free <= 0;
      m_ovr  <= 1'b0;
      m_d    <= '0;
      m_r    <= '0;
    end else begin
      m_edge <= m_edge + 1;
      m_prev <= in_rdy;
      if (in_rdy && !m_prev) begin
        if (m_edge + 1 >= m_free) begin
          m_k    <= m_edge + 1;
          m_free <= m_edge + 4 + HOLD;
        end else begin
          m_ovr <= 1'b1;
        end
      end
      if (m_edge + 1 == m_k + 1) begin
        m_d <= data_in;
        m_r <= ref_in;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cyc_en) begin
      automatic int   e    = m_edge;
      automatic bit   ebsy = (e >= m_k) && (e < m_k + 2 + HOLD);
      automatic bit   erdy = (e >= m_k + 2) && (e < m_k + 2 + HOLD);
      automatic int   diff = int'(m_d) - int'(m_r);
      automatic logic [1:0] ec = 2'd0;
      automatic logic [7:0] em = 8'd0;
      if (erdy) begin
        ec = (diff < 0) ? 2'd1 : (diff == 0) ? 2'd2 : 2'd3;
        em = 8'((diff < 0) ? -diff : diff);
      end
      chk("cycle{rdy,busy,ovr,cmp,data}",
          {17'd0, out_rdy, busy, ovr_err, cmp_state, data_out},
          {17'd0, erdy, ebsy, m_ovr, ec, em});
    end
  end

  // Caller sits at a negedge with in_rdy low; the start edge is the next posedge.
  task automatic txn(input logic signed [7:0] d, input logic signed [7:0] r,
                     input logic [1:0] ec, input logic [7:0] em);
    in_rdy  = 1'b1;
    data_in = 8'($urandom);
    ref_in  = 8'($urandom);
    @(negedge clk);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    data_in = d;
    ref_in  = r;
    @(negedge clk);
    data_in = 8'($urandom);
    ref_in  = 8'($urandom);
    in_rdy  = 1'b0;
    @(negedge clk);
    chk("txn_out_rdy", {31'd0, out_rdy}, 32'd1);
    chk("txn_cmp", {30'd0, cmp_state}, {30'd0, ec});
    chk("txn_mag", {24'd0, data_out}, {24'd0, em});
    repeat (HOLD) @(negedge clk);
    chk("txn_cleared", {22'd0, out_rdy, cmp_state, data_out}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", {20'd0, out_rdy, cmp_state, data_out, busy, ovr_err}, 32'd0);
    rst_n  = 1'b1;
    cyc_en = 1'b1;
    @(negedge clk);

    // Shortfall, exact, change, extremes (last pair is back-to-back)
    txn(-8'sd6, 8'sd0, 2'b01, 8'd6);
    @(negedge clk);
    txn(8'sd0, 8'sd0, 2'b10, 8'd0);
    @(negedge clk);
    txn(8'sd10, 8'sd4, 2'b11, 8'd6);
    @(negedge clk);
    txn(8'sd127, -8'sd128, 2'b11, 8'd255);
    txn(-8'sd128, 8'sd127, 2'b01, 8'd255);
    @(negedge clk);

    // Level held high for 10 cycles: one transaction, no overrun
    in_rdy  = 1'b1;
    data_in = 8'sd3;
    ref_in  = 8'sd3;
    repeat (10) @(negedge clk);
    in_rdy = 1'b0;
    @(negedge clk);
    chk("level_no_ovr", {31'd0, ovr_err}, 32'd0);

    // Pulse during OUT: dropped, sticky ovr_err
    in_rdy = 1'b1;
    @(negedge clk);
    data_in = 8'sd1;
    ref_in  = 8'sd2;
    in_rdy  = 1'b0;
    repeat (2) @(negedge clk);
    chk("ovr_rdy_high", {31'd0, out_rdy}, 32'd1);
    in_rdy = 1'b1;
    @(negedge clk);
    in_rdy = 1'b0;
    chk("ovr_set", {31'd0, ovr_err}, 32'd1);
    repeat (8) @(negedge clk);
    chk("ovr_sticky", {31'd0, ovr_err}, 32'd1);
    chk("ovr_idle", {31'd0, busy}, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_rdy  = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
      ref_in  = 8'($urandom);
      @(negedge clk);
    end
    in_rdy = 1'b0;
    repeat (HOLD + 4) @(negedge clk);

    // Async reset in the middle of OUT, between clock edges
    in_rdy = 1'b1;
    @(negedge clk);
    data_in = 8'sd20;
    ref_in  = 8'sd5;
    in_rdy  = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_rdy", {31'd0, out_rdy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_zero", {20'd0, out_rdy, cmp_state, data_out, busy, ovr_err}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    txn(8'sd20, 8'sd5, 2'b11, 8'd15);
    @(negedge clk);
    chk("post_reset_ovr", {31'd0, ovr_err}, 32'd0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/compare_gen.md
Name: compare_gen

Overview:
- Parametrised successor to the 8-bit ticket-machine compare stage.
- Takes a signed amount through the same in_RDY-then-data handshake and compares it against a per-transaction signed reference (ticket price, or 0 for a balance check).
- Reports a three-way result and the unsigned magnitude of the difference: change due, or shortfall.
- Sits between the coin-accumulator and the change/dispense controller.

Parameters:
- WIDTH, 8: data/reference width in bits (signed, two's complement); legal range is 4 or more.
- HOLD, 4: number of cycles out_rdy and the result are held valid; legal range is 1 or more.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- in_rdy  in  1  request level from upstream; a 0->1 transition starts a transaction.
- data_in  in  WIDTH  signed amount; sampled one cycle after the start edge.
- ref_in  in  WIDTH  signed reference; sampled together with data_in.
- out_rdy  out  1  result valid; high for exactly HOLD cycles per transaction.
- cmp_state  out  2  result code: 00 none, 01 LESS (data<ref), 10 EQUAL, 11 GREATER.
- data_out  out  WIDTH  unsigned magnitude, equal to abs(data - ref).
- busy  out  1  high whenever the FSM is not in IDLE.
- ovr_err  out  1  sticky flag for a start edge that was dropped.

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE. out_rdy, cmp_state, data_out, busy, ovr_err and all internal registers go to 0, with no clock required. This also applies mid-transaction; a partial transaction is discarded.
- Start detect: the registered copy in_rdy_q (reset 0) gives start = in_rdy & ~in_rdy_q. A level held high does not retrigger.
- FSM states, all registered: IDLE, CAPTURE, EVAL, OUT.
- IDLE: if start, go to CAPTURE, else stay in IDLE.
- CAPTURE: one cycle. At its closing edge, data_in and ref_in are latched into d_r and r_r. Go to EVAL.
- EVAL: one cycle. Compute diff = sext(d_r) - sext(r_r) in WIDTH+1 bits. At the closing edge, register cmp_state and data_out = abs(diff), set out_rdy=1, load hold_cnt=HOLD-1, and go to OUT.
- OUT: outputs are held stable. hold_cnt decrements each cycle. When hold_cnt==0, the next edge clears out_rdy, cmp_state and data_out to 0 and returns to IDLE.
- Latency: start seen at edge k; data sampled at k+1; out_rdy rises at k+2; out_rdy falls at k+2+HOLD.
- Width rule: abs(diff) is at most 2^WIDTH-1, so it always fits WIDTH unsigned bits. No saturation is needed; the truncation drops only the sign bit.
- busy = (state != IDLE).
- Overrun: a start edge seen in any state other than IDLE is dropped and sets ovr_err=1. ovr_err is cleared only by reset.
- A start edge on the same edge that OUT returns to IDLE counts as an overrun. The next start is accepted only from IDLE.
- in_rdy may fall at any point after the start edge without affecting the transaction.
- data_in and ref_in are don't-care outside the CAPTURE cycle.

Decomposition:
- Shared package compare_pkg holds:
  - the cmp_state codes CMP_NONE, CMP_LESS, CMP_EQUAL, CMP_GREATER;
  - the FSM state encodings S_IDLE, S_CAPTURE, S_EVAL, S_OUT.
- One combinational sub-module, compare_diff_abs (param WIDTH):
  - inputs are the signed a and b;
  - outputs are the 2-bit code and the WIDTH-bit abs(a-b).
- compare_gen instantiates compare_diff_abs once and owns the FSM, hold counter and error flag.

Test Plan (WIDTH=8, HOLD=4, ref_in=0 unless noted):
- Shortfall: in_rdy 0->1; next cycle data_in=8'hFA (-6) -> two cycles after start, out_rdy=1 for 4 cycles, cmp_state=01, data_out=6; afterwards all three return to 0.
- Exact and change: data_in=0 -> cmp_state=10, data_out=0. Then data_in=10, ref_in=4 -> cmp_state=11, data_out=6.
- Extremes: data_in=127, ref_in=-128 -> cmp_state=11, data_out=255. Then data_in=-128, ref_in=127 -> cmp_state=01, data_out=255.
- Level hold and overrun: hold in_rdy=1 for 10 cycles -> exactly one transaction and ovr_err stays 0. Pulse in_rdy 0->1 again while out_rdy=1 -> pulse ignored, ovr_err=1 until reset.
- Back-to-back: new start edge in the first IDLE cycle after out_rdy falls -> accepted, busy=1 on the next cycle, correct result.
- Async reset: drop rst to 0 mid-OUT, between clock edges -> out_rdy, cmp_state, data_out, busy and ovr_err go to 0 immediately. After rst=1, a new transaction completes normally.
